// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered read data, occupancy
// count, threshold flags and sticky overflow/underflow error flags.
//
// Ports
//   clk_i            clock, every state update happens on its rising edge
//   rst_n_i          synchronous active-low reset
//   wr_en_i/wr_data_i  push request and the word to push
//   rd_en_i          pop request
//   rd_data_o        registered popped word, held while no pop occurs
//   rd_valid_o       one-cycle pulse, rd_data_o holds a freshly popped word
//   full_o/empty_o/almost_full_o/almost_empty_o  status from the count
//   count_o          occupancy, 0..DEPTH
//   overflow_o/underflow_o  sticky errors, cleared by clr_err_i
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  clr_err_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  // Flags come straight from the registered count, so they move on the
  // same edge as count itself.
  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);

  // Acceptance uses the pre-edge flags: a full FIFO still accepts a read
  // alongside a rejected write, and an empty one the reverse.
  assign wr_acc = wr_en_i & ~full_o;
  assign rd_acc = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A new error in the clearing cycle wins over the clear.
    ovf_d = (ovf_q & ~clr_err_i) | (wr_en_i & full_o);
    unf_d = (unf_q & ~clr_err_i) | (rd_en_i & empty_o);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage is never cleared; a write on a reset edge is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed stimulus against fifo_sync_param at default
// parameters, with a queue-based reference model compared every cycle and
// literal expectations at the interesting points.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, afull, aempty, ovf, unf;
  logic [4:0] count;

  int ntests = 0;
  int nfail  = 0;

  fifo_sync_param dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .full_o(full), .empty_o(empty), .almost_full_o(afull),
    .almost_empty_o(aempty), .count_o(count), .overflow_o(ovf),
    .underflow_o(unf), .clr_err_i(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue holding the FIFO contents.
  logic [7:0] m_q[$];
  logic [7:0] m_rdata;
  bit         m_vld, m_ovf, m_unf, m_init;
  int         sz;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_rdata = 8'h00; m_vld = 0; m_ovf = 0; m_unf = 0; m_init = 1;
    end else if (m_init) begin
      sz    = m_q.size();
      m_vld = rd_en && (sz > 0);
      m_ovf = (m_ovf && !clr_err) || (wr_en && sz == 16);
      m_unf = (m_unf && !clr_err) || (rd_en && sz == 0);
      if (m_vld) m_rdata = m_q.pop_front();
      if (wr_en && sz < 16) m_q.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("m_count",    count,    m_q.size());
      chk("m_full",     full,     m_q.size() == 16);
      chk("m_empty",    empty,    m_q.size() == 0);
      chk("m_afull",    afull,    m_q.size() >= 12);
      chk("m_aempty",   aempty,   m_q.size() <= 4);
      chk("m_rd_valid", rd_valid, m_vld);
      chk("m_rd_data",  rd_data,  m_rdata);
      chk("m_overflow", ovf,      m_ovf);
      chk("m_underflow",unf,      m_unf);
    end
  end

  // Drive one cycle of inputs, then return at the following negedge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic c = 1'b0, input logic rn = 1'b1);
    wr_en = w; wr_data = d; rd_en = r; clr_err = c; rst_n = rn;
    @(posedge clk);
    @(negedge clk);
    wr_en = 0; rd_en = 0; clr_err = 0; rst_n = 1;
  endtask

  initial begin
    rst_n = 0; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = 8'h00;
    @(negedge clk);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", aempty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);

    // Fill with 0x01..0x10; almost_full rises when count reaches 12.
    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0);
      if (i == 11) chk("af_at11", afull, 0);
      if (i == 12) chk("af_at12", afull, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    step(1, 8'hEE, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 16);

    // Sticky clear, then clear racing a new overflow.
    step(0, 8'h00, 0, 1);
    chk("ovf_clr", ovf, 0);
    step(1, 8'hEE, 0, 1);
    chk("ovf_clr_race", ovf, 1);
    step(0, 8'h00, 0, 1);

    // Drain in order.
    for (int i = 1; i <= 16; i++) begin
      step(0, 8'h00, 1);
      chk("pop_valid", rd_valid, 1);
      chk("pop_data", rd_data, i);
    end
    chk("drain_empty", empty, 1);
    step(0, 8'h00, 1);
    chk("unf_set", unf, 1);
    chk("unf_valid", rd_valid, 0);
    chk("unf_hold", rd_data, 8'h10);
    step(0, 8'h00, 0, 1);

    // Simultaneous at empty: write wins, read rejected.
    step(1, 8'hA0, 1);
    chk("sim_empty_count", count, 1);
    chk("sim_empty_unf", unf, 1);
    chk("sim_empty_valid", rd_valid, 0);
    step(0, 8'h00, 0, 1);
    for (int i = 1; i < 16; i++) step(1, 8'(8'hA0 + i), 0);
    // Simultaneous at full: read wins, write rejected.
    step(1, 8'hFF, 1);
    chk("sim_full_count", count, 15);
    chk("sim_full_ovf", ovf, 1);
    chk("sim_full_data", rd_data, 8'hA0);
    step(0, 8'h00, 0, 1);
    while (count != 0 && ntests < 100000) step(0, 8'h00, 1);

    // Steady state at count 5 across pointer wraps.
    for (int k = 0; k < 5; k++) step(1, 8'(8'h20 + k), 0);
    for (int k = 0; k < 40; k++) begin
      step(1, 8'(8'h30 + k), 1);
      chk("stream_count", count, 5);
      chk("stream_data", rd_data, (k < 5) ? 8'(8'h20 + k) : 8'(8'h30 + k - 5));
    end
    for (int k = 35; k < 40; k++) begin
      step(0, 8'h00, 1);
      chk("stream_tail", rd_data, 8'(8'h30 + k));
    end

    // Reset mid-traffic at count 9 with a pending error and read.
    step(0, 8'h00, 1);
    for (int k = 0; k < 9; k++) step(1, 8'(8'h50 + k), 0);
    chk("pre_rst_count", count, 9);
    step(0, 8'h00, 1, 0, 0);
    chk("rst2_count", count, 0);
    chk("rst2_empty", empty, 1);
    chk("rst2_valid", rd_valid, 0);
    chk("rst2_data", rd_data, 0);
    chk("rst2_unf", unf, 0);
    chk("rst2_ovf", ovf, 0);

    step(1, 8'h77, 0);
    step(0, 8'h00, 1);
    chk("post_rst_data", rd_data, 8'h77);
    step(0, 8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, meaning the width in bits of each stored word.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 4, meaning the pointer width; storage depth is DEPTH = 2**ADDR_WIDTH, default 16.
REQ-003 The block SHALL take parameter AF_THRESH, default 12, meaning the almost_full assert level, legal range 1..DEPTH.
REQ-004 The block SHALL take parameter AE_THRESH, default 4, meaning the almost_empty assert level, legal range 0..DEPTH-1.
REQ-005 The block SHALL have port clk, input, width 1: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst_n, input, width 1: synchronous active-low reset.
REQ-007 The block SHALL have port wr_en, input, width 1: write request.
REQ-008 The block SHALL have port wr_data, input, width DATA_WIDTH: write word.
REQ-009 The block SHALL have port rd_en, input, width 1: read request.
REQ-010 The block SHALL have port rd_data, output, width DATA_WIDTH: registered read word.
REQ-011 The block SHALL have port rd_valid, output, width 1: rd_data holds a newly popped word this cycle.
REQ-012 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of width 1: status flags.
REQ-013 The block SHALL have port count, output, width ADDR_WIDTH+1: occupancy, range 0..DEPTH.
REQ-014 The block SHALL have ports overflow and underflow, each an output of width 1: sticky error flags.
REQ-015 The block SHALL have port clr_err, input, width 1: clears the sticky error flags.

Function
REQ-016 Write accepted iff wr_en=1 and full=0 at the clock edge; wr_data stored at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-017 Read accepted iff rd_en=1 and empty=0 at the clock edge; word at rd_ptr is registered to rd_data; rd_ptr increments modulo DEPTH.
REQ-018 Read latency: rd_data and rd_valid=1 appear the cycle after the accepting edge; rd_valid pulses for exactly one cycle per accepted read.
REQ-019 When no read is accepted, rd_data holds its previous value (not zeroed) and rd_valid=0.
REQ-020 count next value: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
REQ-021 Flags derive from registered count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH); they update on the same edge as count.
REQ-022 Simultaneous wr_en and rd_en when 0<count<DEPTH: both accepted, count unchanged, pointers both advance.
REQ-023 Simultaneous wr_en and rd_en when full: read accepted, write rejected (full evaluated pre-edge), count becomes DEPTH-1, overflow set.
REQ-024 Simultaneous wr_en and rd_en when empty: write accepted, read rejected, count becomes 1, underflow set, rd_valid stays 0.
REQ-025 A write rejected due to full sets overflow; memory, pointers and count are unchanged.
REQ-026 A read rejected due to empty sets underflow; rd_data, pointers and count are unchanged.
REQ-027 overflow and underflow stay 1 until an edge with clr_err=1; a new error in the same cycle as clr_err leaves the flag set.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order is strictly first-in first-out across wraps.

Reset
REQ-029 On an edge with rst_n=0: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-030 Reset has priority over all other inputs; an in-flight read or write on a reset edge is discarded.
REQ-031 Storage array contents are not reset; they are unobservable until rewritten.

Verification (defaults DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-032 Write 0x01..0x10 (16 words) -> full=1, count=16, almost_full first rises on the edge count reaches 12; a 17th write -> overflow=1, count stays 16.
REQ-033 Pop 16 words from full -> rd_data 0x01..0x10 in order, each one cycle after rd_en with rd_valid=1; then empty=1, and a further rd_en -> underflow=1, rd_valid=0.
REQ-034 Interleave 40 writes/reads with continuous simultaneous wr_en+rd_en at count=5 -> count stays 5 and the output order matches the input order across two pointer wraps.
REQ-035 At full, assert wr_en=rd_en=1 for one cycle -> count=15, overflow=1; at empty, the same -> count=1, underflow=1.
REQ-036 Assert rst_n=0 at count=9 with rd_en=1 -> next cycle count=0, empty=1, rd_valid=0, rd_data=0x00, flags clear.
REQ-037 Set overflow, then pulse clr_err -> overflow=0; clr_err concurrent with an overflowing write -> overflow remains 1.
